// File: rtl/aes_pkg.sv
// Shared definitions for the AES-192 AXI4-lite sequencer: default register map,
// block geometry and the two state encodings used by the bus sequencer.
package aes_pkg;

  localparam logic [31:0] AES_START_ADDR_DEF = 32'h0000_0000;
  localparam logic [31:0] AES_DONE_ADDR_DEF  = 32'h0000_0004;
  localparam logic [31:0] AES_PT_BASE_DEF    = 32'h0000_0008;
  localparam logic [31:0] AES_KEY_BASE_DEF   = 32'h0000_0018;
  localparam logic [31:0] AES_CT_BASE_DEF    = 32'h0000_0030;

  localparam int AES_KEY_WORDS   = 6;
  localparam int AES_BLOCK_WORDS = 4;
  localparam int BYTES_PER_WORD  = 4;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Which part of the register sequence the bus engine is working through.
  typedef enum logic [2:0] {
    PH_KEY   = 3'd0,
    PH_PT    = 3'd1,
    PH_START = 3'd2,
    PH_POLL  = 3'd3,
    PH_CT    = 3'd4
  } phase_e;

  // AXI4-lite bus engine state; exactly one transaction outstanding at a time.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WR_B  = 3'd2,
    ST_RD_AR = 3'd3,
    ST_RD_R  = 3'd4,
    ST_RESP  = 3'd5
  } bus_state_e;

endpackage

// File: rtl/aes_axil_sequencer.sv
// AXI4-lite master that runs one AES-192 block operation on the AES core:
// writes key and plaintext, starts the core, polls done, reads ciphertext and
// hands the result back on a valid/ready port.
//
// Handshakes: every channel here transfers on a cycle where valid && ready are
// both high at the rising clock edge. A valid, once raised, stays high with
// stable payload until its ready is seen; ready never depends on the partner
// valid combinationally within this block.
module aes_axil_sequencer
  import aes_pkg::*;
#(
  parameter int              AW             = 32,
  parameter int              DW             = 32,
  parameter logic [AW-1:0]   AES_START_ADDR = AW'(AES_START_ADDR_DEF),
  parameter logic [AW-1:0]   AES_DONE_ADDR  = AW'(AES_DONE_ADDR_DEF),
  parameter logic [AW-1:0]   AES_PT_BASE    = AW'(AES_PT_BASE_DEF),
  parameter logic [AW-1:0]   AES_KEY_BASE   = AW'(AES_KEY_BASE_DEF),
  parameter logic [AW-1:0]   AES_CT_BASE    = AW'(AES_CT_BASE_DEF),
  parameter int              POLL_MAX       = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // request
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [191:0]      req_key_i,
  input  logic [127:0]      req_pt_i,
  // result
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [127:0]      res_ct_o,
  output logic              res_err_o,
  // AXI4-lite master
  output logic [AW-1:0]     m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DW-1:0]     m_axi_wdata,
  output logic [DW/8-1:0]   m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [AW-1:0]     m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DW-1:0]     m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  // debug
  output logic [2:0]        dbg_state_o
);

  localparam logic [2:0]  KEY_LAST  = 3'(AES_KEY_WORDS - 1);
  localparam logic [2:0]  BLK_LAST  = 3'(AES_BLOCK_WORDS - 1);
  localparam logic [10:0] POLL_LAST = 11'(POLL_MAX - 1);

  bus_state_e     state_q, state_d;
  phase_e         phase_q, phase_d;
  logic [2:0]     idx_q, idx_d;
  logic [10:0]    poll_q, poll_d;
  logic           err_q, err_d;
  logic [127:0]   ct_q, ct_d;
  logic [191:0]   key_q, key_d;
  logic [127:0]   pt_q, pt_d;
  logic           aw_pend_q, aw_pend_d;
  logic           w_pend_q, w_pend_d;

  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;
  logic [31:0]    wr_data;

  // State register; async reset drops every valid immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers: phase/index/poll counters, captured request, result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q   <= PH_KEY;
      idx_q     <= '0;
      poll_q    <= '0;
      err_q     <= 1'b0;
      ct_q      <= '0;
      key_q     <= '0;
      pt_q      <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      poll_q    <= poll_d;
      err_q     <= err_d;
      ct_q      <= ct_d;
      key_q     <= key_d;
      pt_q      <= pt_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  // Next-state and sequencing: walks KEY -> PT -> START -> POLL -> CT -> RESP.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    poll_d    = poll_q;
    err_d     = err_q;
    ct_d      = ct_q;
    key_d     = key_q;
    pt_d      = pt_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          key_d     = req_key_i;
          pt_d      = req_pt_i;
          err_d     = 1'b0;
          ct_d      = '0;
          phase_d   = PH_KEY;
          idx_d     = '0;
          poll_d    = '0;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = ST_WR;
        end
      end
      ST_WR: begin
        // aw and w retire independently; leave once both have been taken.
        if (m_axi_awready) aw_pend_d = 1'b0;
        if (m_axi_wready)  w_pend_d  = 1'b0;
        if ((!aw_pend_q || m_axi_awready) && (!w_pend_q || m_axi_wready))
          state_d = ST_WR_B;
      end
      ST_WR_B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_RESP_OKAY) begin
            err_d   = 1'b1;
            ct_d    = '0;
            state_d = ST_RESP;
          end else begin
            case (phase_q)
              PH_KEY: begin
                state_d   = ST_WR;
                aw_pend_d = 1'b1;
                w_pend_d  = 1'b1;
                if (idx_q == KEY_LAST) begin
                  phase_d = PH_PT;
                  idx_d   = '0;
                end else begin
                  idx_d = idx_q + 3'd1;
                end
              end
              PH_PT: begin
                state_d   = ST_WR;
                aw_pend_d = 1'b1;
                w_pend_d  = 1'b1;
                if (idx_q == BLK_LAST) begin
                  phase_d = PH_START;
                  idx_d   = '0;
                end else begin
                  idx_d = idx_q + 3'd1;
                end
              end
              default: begin
                phase_d = PH_POLL;
                poll_d  = '0;
                state_d = ST_RD_AR;
              end
            endcase
          end
        end
      end
      ST_RD_AR: begin
        if (m_axi_arready) state_d = ST_RD_R;
      end
      ST_RD_R: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != AXI_RESP_OKAY) begin
            err_d   = 1'b1;
            ct_d    = '0;
            state_d = ST_RESP;
          end else if (phase_q == PH_POLL) begin
            if (m_axi_rdata[0]) begin
              phase_d = PH_CT;
              idx_d   = '0;
              state_d = ST_RD_AR;
            end else if (poll_q == POLL_LAST) begin
              // Core never finished: report a timeout with an all-zero block.
              err_d   = 1'b1;
              ct_d    = '0;
              state_d = ST_RESP;
            end else begin
              poll_d  = poll_q + 11'd1;
              state_d = ST_RD_AR;
            end
          end else begin
            for (int w = 0; w < AES_BLOCK_WORDS; w++)
              if (idx_q == 3'(w)) ct_d[(AES_BLOCK_WORDS-1-w)*32 +: 32] = m_axi_rdata[31:0];
            if (idx_q == BLK_LAST) begin
              state_d = ST_RESP;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = ST_RD_AR;
            end
          end
        end
      end
      ST_RESP: begin
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/data selection from phase and word index. Key and plaintext
  // word 0 land at the highest register address of their block.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    case (phase_q)
      PH_KEY: begin
        wr_addr = AES_KEY_BASE + AW'(KEY_LAST - idx_q) * AW'(BYTES_PER_WORD);
        for (int w = 0; w < AES_KEY_WORDS; w++)
          if (idx_q == 3'(w)) wr_data = key_q[(AES_KEY_WORDS-1-w)*32 +: 32];
      end
      PH_PT: begin
        wr_addr = AES_PT_BASE + AW'(BLK_LAST - idx_q) * AW'(BYTES_PER_WORD);
        for (int w = 0; w < AES_BLOCK_WORDS; w++)
          if (idx_q == 3'(w)) wr_data = pt_q[(AES_BLOCK_WORDS-1-w)*32 +: 32];
      end
      PH_START: begin
        wr_addr = AES_START_ADDR;
        wr_data = 32'h1;
      end
      PH_POLL: rd_addr = AES_DONE_ADDR;
      PH_CT:   rd_addr = AES_CT_BASE + AW'(idx_q) * AW'(BYTES_PER_WORD);
      default: ;
    endcase
  end

  // Payloads are driven only while their channel is pending, zero otherwise.
  assign m_axi_awvalid = aw_pend_q;
  assign m_axi_awaddr  = aw_pend_q ? wr_addr : '0;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = w_pend_q;
  assign m_axi_wdata   = w_pend_q ? DW'(wr_data) : '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = (state_q == ST_WR_B);
  assign m_axi_arvalid = (state_q == ST_RD_AR);
  assign m_axi_araddr  = (state_q == ST_RD_AR) ? rd_addr : '0;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = (state_q == ST_RD_R);

  assign req_ready_o = (state_q == ST_IDLE);
  assign res_valid_o = (state_q == ST_RESP);
  assign res_ct_o    = ct_q;
  assign res_err_o   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes_axil_sequencer.sv
// Directed bench for aes_axil_sequencer with a behavioural AXI4-lite AES
// register slave (optional ready skew, error injection, programmable done).
module tb_aes_axil_sequencer;
  import aes_pkg::*;

  localparam int TB_POLL_MAX = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [191:0] req_key = '0;
  logic [127:0] req_pt = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_ct;
  logic         res_err;
  logic [31:0]  awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready = 1'b0;
  logic [1:0]   bresp = 2'b00;
  logic         bvalid = 1'b0;
  logic         bready;
  logic [31:0]  araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = 2'b00;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [2:0]   dbg_state;

  aes_axil_sequencer #(.POLL_MAX(TB_POLL_MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_key_i(req_key), .req_pt_i(req_pt),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_ct_o(res_ct), .res_err_o(res_err),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .dbg_state_o(dbg_state)
  );

  // ---------------- vectors ----------------
  localparam logic [191:0] KEY1 = 192'h2b7e1516_28aed2a6_abf71588_09cf4f3c_2b7e1516_28aed2a6;
  localparam logic [127:0] PT1  = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] CT1  = 128'h4fcb8db8_5784a2c1_bb77db7e_de3217ac;
  localparam logic [191:0] KEY2 = 192'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617;
  localparam logic [127:0] PT2  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT2  = 128'hdda97ca4_864cdfe0_6eaf70a0_ec0d7191;
  localparam logic [191:0] KEY3 = 192'hffeeddcc_bbaa9988_77665544_33221100_deadbeef_cafef00d;
  localparam logic [127:0] PT3  = 128'h0badc0de_12345678_9abcdef0_55aa55aa;
  localparam logic [127:0] CT3  = 128'h11111111_22222222_33333333_44444444;

  // Write address order: key words 0..5, plaintext words 0..3, start.
  localparam logic [31:0] WR_ADDR [11] = '{32'h2C, 32'h28, 32'h24, 32'h20, 32'h1C, 32'h18,
                                           32'h14, 32'h10, 32'h0C, 32'h08, 32'h00};

  // ---------------- slave model state ----------------
  logic [31:0]  wa_log[$];
  logic [31:0]  wd_log[$];
  logic [31:0]  ar_log[$];
  logic [31:0]  exp_q[$];
  logic [127:0] ct_mem;
  logic [31:0]  ar_addr;
  int   skew_en = 0;
  int   err_at = -1;
  int   done_after = 0;
  int   done_cnt = 0;
  int   b_count = 0;
  int   bad_strb = 0;
  bit   aw_got, w_got, ar_got, b_fire, r_fire;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: decides readies/responses on the falling edge, so every handshake
  // it records here completes at the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    end else begin
      if (b_fire) begin bvalid = 0; b_fire = 0; end
      if (r_fire) begin rvalid = 0; r_fire = 0; end
      if (aw_got && w_got && !bvalid) begin
        bvalid = 1;
        bresp  = (b_count == err_at) ? 2'b10 : 2'b00;
        b_count++;
        aw_got = 0; w_got = 0;
      end
      if (ar_got && !rvalid) begin
        rvalid = 1; rresp = 2'b00;
        if (ar_addr == 32'h04) begin
          rdata = 32'hA5A5_A5A4 | ((done_cnt >= done_after) ? 32'h1 : 32'h0);
          done_cnt++;
        end else if (ar_addr >= 32'h30 && ar_addr <= 32'h3C) begin
          case (ar_addr)
            32'h30:  rdata = ct_mem[127:96];
            32'h34:  rdata = ct_mem[95:64];
            32'h38:  rdata = ct_mem[63:32];
            default: rdata = ct_mem[31:0];
          endcase
        end else begin
          rdata = 32'hBAD0_0000;
        end
        ar_got = 0;
      end
      b_fire  = bvalid && bready;
      r_fire  = rvalid && rready;
      awready = awvalid && (skew_en == 0 || $urandom_range(0, 2) != 0);
      wready  = wvalid  && (skew_en == 0 || $urandom_range(0, 2) != 0);
      arready = arvalid;
      if (awvalid && awready) begin
        wa_log.push_back(awaddr);
        if (awprot != 3'b000) bad_strb++;
        aw_got = 1;
      end
      if (wvalid && wready) begin
        wd_log.push_back(wdata);
        if (wstrb != 4'hF) bad_strb++;
        w_got = 1;
      end
      if (arvalid && arready) begin
        ar_log.push_back(araddr);
        ar_addr = araddr;
        ar_got = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic setup_model(input int skew, input int err_idx, input int done_n, input logic [127:0] ct);
    skew_en = skew; err_at = err_idx; done_after = done_n; ct_mem = ct;
    done_cnt = 0; b_count = 0; bad_strb = 0;
    wa_log.delete(); wd_log.delete(); ar_log.delete();
  endtask

  task automatic send_req(input logic [191:0] k, input logic [127:0] p);
    int n = 0;
    req_key = k; req_pt = p; req_valid = 1;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("req_accept", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 400) begin @(negedge clk); n++; end
    check(tag, res_valid, 1'b1);
  endtask

  task automatic take_res();
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  task automatic check_writes(input logic [191:0] k, input logic [127:0] p);
    logic [31:0] e;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(k[191-32*i -: 32]);
    for (int i = 0; i < 4; i++) exp_q.push_back(p[127-32*i -: 32]);
    exp_q.push_back(32'h1);
    check("wr_addr_count", wa_log.size(), 11);
    check("wr_data_count", wd_log.size(), 11);
    check("wr_strb_prot", bad_strb, 0);
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      if (i < wa_log.size()) check($sformatf("wr_addr[%0d]", i), wa_log[i], WR_ADDR[i]);
      if (i < wd_log.size()) check($sformatf("wr_data[%0d]", i), wd_log[i], e);
    end
  endtask

  task automatic check_reads(input int polls);
    exp_q.delete();
    for (int i = 0; i < polls; i++) exp_q.push_back(32'h04);
    exp_q.push_back(32'h30); exp_q.push_back(32'h34);
    exp_q.push_back(32'h38); exp_q.push_back(32'h3C);
    check("rd_count", ar_log.size(), polls + 4);
    for (int i = 0; i < polls + 4; i++)
      if (i < ar_log.size()) check($sformatf("rd_addr[%0d]", i), ar_log[i], exp_q[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    ct_mem = '0;
    repeat (2) @(negedge clk);
    // reset state
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_err", res_err, 1'b0);
    check("rst_res_ct", res_ct, '0);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check("rst_addr_data", {awaddr, wdata, araddr}, '0);
    #2 rst_n = 1;
    @(negedge clk);
    check("idle_state", dbg_state, ST_IDLE);

    // 1: reference AES-192 vector, two busy polls
    setup_model(0, -1, 2, CT1);
    send_req(KEY1, PT1);
    wait_res("t1_res_valid");
    check("t1_ct", res_ct, CT1);
    check("t1_err", res_err, 1'b0);
    check_writes(KEY1, PT1);
    check_reads(3);
    take_res();
    check("t1_back_idle", req_ready, 1'b1);

    // 2: random aw/w ready skew, done on first poll
    setup_model(1, -1, 0, CT2);
    send_req(KEY2, PT2);
    wait_res("t2_res_valid");
    check("t2_ct", res_ct, CT2);
    check("t2_err", res_err, 1'b0);
    check_writes(KEY2, PT2);
    check_reads(1);
    take_res();

    // 3: SLVERR on third key write stops all traffic
    setup_model(0, 2, 0, CT1);
    send_req(KEY1, PT1);
    wait_res("t3_res_valid");
    repeat (5) @(negedge clk);
    check("t3_valid_hold", res_valid, 1'b1);
    check("t3_err", res_err, 1'b1);
    check("t3_ct", res_ct, '0);
    check("t3_aw_count", wa_log.size(), 3);
    check("t3_w_count", wd_log.size(), 3);
    check("t3_ar_count", ar_log.size(), 0);
    check("t3_bus_quiet", {awvalid, wvalid, arvalid}, 3'b0);
    take_res();

    // 4: done stuck low -> exactly TB_POLL_MAX polls then timeout
    setup_model(0, -1, 1000, CT1);
    send_req(KEY2, PT2);
    wait_res("t4_res_valid");
    check("t4_done_reads", done_cnt, TB_POLL_MAX);
    check("t4_ar_count", ar_log.size(), TB_POLL_MAX);
    check("t4_err", res_err, 1'b1);
    check("t4_ct", res_ct, '0);
    take_res();

    // 5: result back-pressure, then back-to-back request; err cleared on accept
    setup_model(0, -1, 0, CT1);
    send_req(KEY1, PT1);
    wait_res("t5_res_valid");
    setup_model(0, -1, 1, CT3);
    req_key = KEY3; req_pt = PT3; req_valid = 1;
    for (int c = 0; c < 20; c++) begin
      check("t5_ct_stable", res_ct, CT1);
      check("t5_req_ready_low", req_ready, 1'b0);
      @(negedge clk);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    check("t5_req_ready_next", req_ready, 1'b1);
    check("t5_res_valid_drop", res_valid, 1'b0);
    @(negedge clk);
    req_valid = 0;
    check("t5_second_accepted", {req_ready, awvalid, wvalid}, 3'b011);
    wait_res("t5b_res_valid");
    check("t5b_ct", res_ct, CT3);
    check("t5b_err", res_err, 1'b0);
    check_writes(KEY3, PT3);
    take_res();

    // 6: reset while polling, then a clean operation
    setup_model(0, -1, 1000, CT1);
    send_req(KEY2, PT2);
    n = 0;
    while (done_cnt < 2 && n < 200) begin @(negedge clk); n++; end
    check("t6_reached_poll", done_cnt >= 2, 1'b1);
    #2 rst_n = 0;
    #1;
    check("t6_valids_low", {awvalid, wvalid, arvalid, bready, rready, res_valid}, 6'b0);
    check("t6_state_idle", dbg_state, ST_IDLE);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("t6_req_ready", req_ready, 1'b1);
    setup_model(0, -1, 1, CT1);
    send_req(KEY1, PT1);
    wait_res("t6_res_valid");
    check("t6_ct", res_ct, CT1);
    check("t6_err", res_err, 1'b0);
    check_writes(KEY1, PT1);
    check_reads(2);
    take_res();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_axil_sequencer.md
# aes_axil_sequencer

Hardware AXI4-lite master that drives one AES-192 block operation on the AXI4-lite AES core without software involvement. Accepts a key/plaintext request on a valid/ready port, writes key and plaintext, starts the core, polls its done flag, reads back the ciphertext and returns it on a valid/ready result port. Sits directly upstream of the AES core's AXI4-lite slave port and replaces CPU-driven register sequencing.

## Interface

Parameters:
- AW, 32, AXI address width
- DW, 32, AXI data width; only 32 supported
- AES_START_ADDR, 32'h0000, start register; write 1 to launch
- AES_DONE_ADDR, 32'h0004, done register; bit 0 = done
- AES_PT_BASE, 32'h0008, plaintext base, 4 words
- AES_KEY_BASE, 32'h0018, key base, 6 words
- AES_CT_BASE, 32'h0030, ciphertext base, 4 words
- POLL_MAX, 1024, maximum done-register reads before timeout

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous active-low reset
- req_valid_i / req_ready_o  in/out  1  request handshake
- req_key_i  in  192  key; bits [191:160] are word 0
- req_pt_i  in  128  plaintext; bits [127:96] are word 0
- res_valid_o / res_ready_i  out/in  1  result handshake
- res_ct_o  out  128  ciphertext; bits [127:96] are CT word 0
- res_err_o  out  1  bus error or poll timeout
- m_axi_aw{addr,valid}/awready, w{data,strb,valid}/wready, bresp/bvalid/bready, ar{addr,valid}/arready, rdata/rresp/rvalid/rready  AXI4-lite master; awprot/arprot tied 3'b000

## Operation

- Request accepted when req_valid_i && req_ready_o; key and pt captured into internal registers.
- Phases in order: KEY (6 writes), PT (4 writes), START (1 write, data 32'h1), POLL (reads of AES_DONE_ADDR until rdata[0]=1), CT (4 reads), then RESP.
- KEY word i (i=0..5) goes to AES_KEY_BASE + (5-i)*4; PT word i goes to AES_PT_BASE + (3-i)*4; CT word i read from AES_CT_BASE + i*4 into res_ct_o[127-32i -: 32].
- Bus FSM states: IDLE, WR (aw/w pending), WR_B, RD_AR, RD_R, RESP. A 3-bit phase register plus a 3-bit word index and an 11-bit poll counter select address/data.
- WR: awvalid and wvalid asserted together, each dropped independently on its own ready; move to WR_B when both accepted (including same cycle). wstrb = 4'hF always.
- WR_B: bready=1; on bvalid, bresp!=OKAY -> set err, go RESP; else advance word/phase.
- RD_AR: arvalid until arready. RD_R: rready=1; on rvalid, rresp!=OKAY -> err, RESP.
- POLL: rdata[0]=0 reissues read; poll counter reaching POLL_MAX -> err, RESP with res_ct_o=0.
- RESP: res_valid_o held with stable data until res_ready_i; then IDLE. res_err_o cleared on next accept.

## Timing

- Reset values: req_ready_o=1, res_valid_o=0, res_err_o=0, res_ct_o=0, all AXI valid/ready outputs 0, addr/data 0.
- req_ready_o=1 only in IDLE; awvalid/wvalid assert the cycle after accept.
- One outstanding AXI transaction; no new address until prior response consumed.
- Zero-wait slave: each write 2 cycles (WR, WR_B), each read 2 cycles; minimum latency accept->res_valid_o = 2*(11+P+4)+1 cycles, P = poll reads.
- AXI valids never drop before their ready (stable addr/data while pending).
- Reset mid-operation: all valids drop immediately, FSM to IDLE; AES core shares reset.
- res_valid_o with res_ready_i already high: one-cycle RESP, req_ready_o high next cycle.

## Structure

- Shared package aes_pkg: address defaults, AES_KEY_WORDS=6, AES_BLOCK_WORDS=4, BYTES_PER_WORD=4, phase enum, bus state enum.
- Single module; no sub-module. Address/data mux is combinational from phase and index.

## Test plan

- Key 2b7e1516 28aed2a6 abf71588 09cf4f3c 2b7e1516 28aed2a6, pt 3243f6a8 885a308d 313198a2 e0370734 against AES core -> res_ct_o = 4fcb8db8_5784a2c1_bb77db7e_de3217ac, res_err_o=0.
- Slave model with random awready/wready skew (w before aw, aw before w, same cycle) -> exact write sequence of 11 addresses and data, no duplicate or lost beat.
- Slave returns bresp=SLVERR on 3rd key write -> no further AXI traffic, res_valid_o=1, res_err_o=1.
- Done stuck at 0, POLL_MAX=8 -> exactly 8 done reads, then res_err_o=1, res_ct_o=0.
- res_ready_i held low 20 cycles -> res_ct_o stable, req_ready_o=0 throughout, back-to-back second request accepted cycle after handshake.
- rst_ni asserted during POLL -> all valids low same cycle, after release req_ready_o=1 and new request completes correctly.
